// File: rtl/maf_seq_ctrl.sv
// Sequencer and valid/ready front-end for the 4-tap mean-average filter.
// Define MAF_SEQ_CTRL_STATS_EN to add output/stall statistics counters.
module maf_seq_ctrl #(
  parameter int N_BITS     = 32,
  parameter int FILL_CNT   = 6,
  parameter int CLR_CYCLES = 2,
  parameter int DECIM_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DECIM_W-1:0] cfg_decim,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BITS-1:0]  in_data,
  output logic               filt_we,
  output logic               filt_rst,
  output logic [N_BITS-1:0]  filt_din,
  input  logic [N_BITS-1:0]  filt_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_BITS-1:0]  out_data,
  output logic               busy,
`ifdef MAF_SEQ_CTRL_STATS_EN
  output logic               fill_done,
  output logic [31:0]        stat_out_cnt,
  output logic [15:0]        stat_stall_cnt
`else
  output logic               fill_done
`endif
);

  localparam int FW = $clog2(FILL_CNT + 1);
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [DECIM_W-1:0] DEC_ONE = DECIM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       clr_q, clr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [DECIM_W-1:0]  dec_q, dec_d;
  logic [DECIM_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic                cap_pend_q, cap_pend_d;
  logic                out_valid_q, out_valid_d;
  logic [N_BITS-1:0]   out_data_q, out_data_d;
  logic                accept;
  logic                out_stall;
  logic                pending;

  assign out_stall = out_valid_q & ~out_ready;
  assign in_ready  = ((state_q == S_FILL) | (state_q == S_RUN))
                   & en & ~cap_pend_q & ~out_stall;
  assign accept    = in_valid & in_ready;
  assign pending   = cap_pend_q | out_valid_q;

  assign filt_we   = accept;
  assign filt_din  = in_data;
  assign filt_rst  = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign fill_done = (state_q == S_RUN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    fill_d      = fill_q;
    dec_d       = dec_q;
    dec_cnt_d   = dec_cnt_q;
    cap_pend_d  = cap_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // Filter registers took the sample at the accept edge; grab it now.
    if (cap_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = filt_dout;
      cap_pend_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        clr_d = '0;
        if (en) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fill_d    = '0;
        dec_cnt_d = '0;
        dec_d     = (cfg_decim == '0) ? DEC_ONE : cfg_decim;
        if (clr_q == CW'(CLR_CYCLES - 1)) begin
          clr_d   = '0;
          state_d = S_FILL;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      S_FILL: begin
        if (!en) begin
          state_d = pending ? S_DRAIN : S_IDLE;
        end else if (accept) begin
          fill_d = fill_q + FW'(1);
          if (fill_q == FW'(FILL_CNT - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = pending ? S_DRAIN : S_IDLE;
        end else if (accept) begin
          if (dec_cnt_q == dec_q - DEC_ONE) begin
            dec_cnt_d  = '0;
            cap_pend_d = 1'b1;
          end else begin
            dec_cnt_d = dec_cnt_q + DEC_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (!cap_pend_q && (!out_valid_q || out_ready)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clr_q       <= '0;
      fill_q      <= '0;
      dec_q       <= '0;
      dec_cnt_q   <= '0;
      cap_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      fill_q      <= fill_d;
      dec_q       <= dec_d;
      dec_cnt_q   <= dec_cnt_d;
      cap_pend_q  <= cap_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MAF_SEQ_CTRL_STATS_EN
  logic [31:0] st_out_q, st_out_d;
  logic [15:0] st_stall_q, st_stall_d;

  always_comb begin
    st_out_d   = st_out_q;
    st_stall_d = st_stall_q;
    if (state_q == S_CLEAR) begin
      st_out_d   = '0;
      st_stall_d = '0;
    end else begin
      if (out_valid_q && out_ready) st_out_d = st_out_q + 32'd1;
      if ((state_q == S_RUN) && in_valid && !in_ready) begin
        st_stall_d = st_stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_out_q   <= '0;
      st_stall_q <= '0;
    end else begin
      st_out_q   <= st_out_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_out_cnt   = st_out_q;
  assign stat_stall_cnt = st_stall_q;
`endif

endmodule

// File: tb/tb_maf_seq_ctrl.sv
// Directed bench for maf_seq_ctrl with a small 4-tap averaging filter model.
// Stats checks run when MAF_SEQ_CTRL_STATS_EN is defined.
module tb_maf_seq_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [7:0]   cfg_decim = 8'd1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         filt_we;
  logic         filt_rst;
  logic [N-1:0] filt_din;
  logic [N-1:0] filt_dout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;
  logic         fill_done;
`ifdef MAF_SEQ_CTRL_STATS_EN
  logic [31:0]  stat_out_cnt;
  logic [15:0]  stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  maf_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_decim (cfg_decim),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .filt_we   (filt_we),
    .filt_rst  (filt_rst),
    .filt_din  (filt_din),
    .filt_dout (filt_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
`ifdef MAF_SEQ_CTRL_STATS_EN
    .fill_done      (fill_done),
    .stat_out_cnt   (stat_out_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`else
    .fill_done (fill_done)
`endif
  );

  // 4-tap averaging filter stand-in
  logic [N-1:0] tap [4];
  logic [N+1:0] tap_sum;
  assign tap_sum = {2'b0, tap[0]} + {2'b0, tap[1]}
                 + {2'b0, tap[2]} + {2'b0, tap[3]};
  assign filt_dout = tap_sum[N+1:2];

  always @(posedge clk) begin
    if (filt_rst) begin
      for (int i = 0; i < 4; i++) tap[i] <= '0;
    end else if (filt_we) begin
      tap[0] <= filt_din;
      for (int i = 1; i < 4; i++) tap[i] <= tap[i-1];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Negedge monitor
  int           cyc = 0;
  logic         acc_seen = 1'b0;
  int           rst_cyc;
  int           we_err;
  int           we_n;
  int           acc_cyc [$];
  int           ov_cyc [$];
  logic [N-1:0] ov_dat [$];

  always @(negedge clk) begin
    acc_seen = in_valid && in_ready;
    if (rst) begin
      cyc++;
      if (filt_we !== acc_seen) we_err++;
      if (filt_we) we_n++;
      if (filt_rst) rst_cyc++;
      if (acc_seen) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        ov_cyc.push_back(cyc);
        ov_dat.push_back(out_data);
      end
    end
  end

  task automatic clear_log();
    rst_cyc = 0;
    we_n = 0;
    acc_cyc.delete();
    ov_cyc.delete();
    ov_dat.delete();
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int n, input logic [31:0] v0,
                      input logic [31:0] step);
    int idx = 0;
    int guard = 0;
    in_valid = 1'b1;
    in_data = v0;
    while (idx < n && guard < 300) begin
      tick();
      guard++;
      if (acc_seen) begin
        idx++;
        in_data = v0 + step * idx;
      end
    end
    in_valid = 1'b0;
    if (guard >= 300) check("feed_timeout", idx, n);
  endtask

  task automatic wait_ov();
    int g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    check("ov_wait", {31'd0, out_valid}, 1);
  endtask

  task automatic restart(input logic [7:0] d);
    en = 1'b0;
    tick(3);
    cfg_decim = d;
    en = 1'b1;
    clear_log();
  endtask

  int bp_err;
  logic [7:0] lit8;

  initial begin
    we_err = 0;
    clear_log();
    tick(2);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_filt_rst", {31'd0, filt_rst}, 0);

    // fill and decim=1 stream
    rst = 1'b1;
    cfg_decim = 8'd1;
    out_ready = 1'b1;
    en = 1'b1;
    clear_log();
    feed(10, 1, 1);
    tick(4);
    check("clr_cycles", rst_cyc, 2);
    check("d1_count", ov_cyc.size(), 4);
    check("d1_latency", ov_cyc[0] - acc_cyc[6], 2);
    check("d1_acc_gap", acc_cyc[7] - acc_cyc[6], 2);
    check("d1_ov_gap", ov_cyc[1] - ov_cyc[0], 2);
    for (int i = 0; i < 4; i++) check($sformatf("d1_data%0d", i), ov_dat[i], 5 + i);
    check("run_fill_done", {31'd0, fill_done}, 1);

    // decim=4, constant input
    restart(8'd4);
    feed(14, 100, 0);
    tick(8);
    check("d4_count", ov_cyc.size(), 2);
    check("d4_data0", ov_dat[0], 100);
    check("d4_data1", ov_dat[1], 100);
    check("d4_latency", ov_cyc[0] - acc_cyc[9], 2);
    check("d4_ov_gap", ov_cyc[1] - ov_cyc[0], 5);

    // decim=0 acts as 1
    lit8 = 8'd0;
    restart(lit8);
    feed(8, 20, 0);
    tick(4);
    check("d0_count", ov_cyc.size(), 2);
    check("d0_data", ov_dat[1], 20);

    // backpressure
    clear_log();
    out_ready = 1'b0;
    feed(1, 40, 0);
    wait_ov();
    check("bp_data", out_data, 25);
    in_valid = 1'b1;
    in_data = 44;
    bp_err = 0;
    repeat (10) begin
      tick();
      if (!out_valid || out_data != 25 || in_ready || filt_we) bp_err++;
    end
    check("bp_hold", bp_err, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ov_clr", {31'd0, out_valid}, 0);
    check("bp_in_ready", {31'd0, in_ready}, 1);
    check("bp_xfers", ov_cyc.size(), 1);

    // disable on emitting accept with result stalled
    clear_log();
    feed(1, 60, 0);
    en = 1'b0;
    check("dis_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b1;
    in_data = 70;
    tick(5);
    check("dis_ov", {31'd0, out_valid}, 1);
    check("dis_data", out_data, 35);
    check("dis_busy", {31'd0, busy}, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dis_idle", {31'd0, busy}, 0);
    tick(4);
    in_valid = 1'b0;
    check("dis_we_n", we_n, 1);

    // async reset with out_valid held
    cfg_decim = 8'd1;
    en = 1'b1;
    clear_log();
    feed(7, 1, 1);
    wait_ov();
    #2 rst = 1'b0;
    #1;
    check("ar_ov", {31'd0, out_valid}, 0);
    check("ar_in_ready", {31'd0, in_ready}, 0);
    check("ar_filt_rst", {31'd0, filt_rst}, 0);
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_data", out_data, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    clear_log();
    feed(10, 1, 1);
    tick(4);
    check("ar_clr_cycles", rst_cyc, 2);
    check("ar_count", ov_cyc.size(), 4);
    check("ar_latency", ov_cyc[0] - acc_cyc[6], 2);
    check("ar_data0", ov_dat[0], 5);

`ifdef MAF_SEQ_CTRL_STATS_EN
    restart(8'd1);
    feed(11, 1, 1);
    tick(4);
    check("st_out", stat_out_cnt, 5);
    check("st_stall", {16'd0, stat_stall_cnt}, 4);
    restart(8'd1);
    tick(3);
    check("st_out_clr", stat_out_cnt, 0);
    check("st_stall_clr", {16'd0, stat_stall_cnt}, 0);
    check("st_fill", {31'd0, fill_done}, 0);
`endif

    check("we_match", we_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
